// File: rtl/tl_a_repeater_if.sv
// TileLink A-channel bundle: valid/ready handshake plus the full A payload.
// The master modport drives a beat and the slave modport accepts it.
interface tl_a_repeater_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 4,
  parameter int SRC_W  = 2
);
  logic                valid;
  logic                ready;
  logic [2:0]          opcode;
  logic [2:0]          param;
  logic [SIZE_W-1:0]   size;
  logic [SRC_W-1:0]    source;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] mask;
  logic [DATA_W-1:0]   data;
  logic                corrupt;

  modport master (
    output valid, opcode, param, size, source, address, mask, data, corrupt,
    input  ready
  );

  modport slave (
    input  valid, opcode, param, size, source, address, mask, data, corrupt,
    output ready
  );
endinterface

// File: rtl/tl_a_repeater.sv
// tl_a_repeater: single-entry TileLink A-channel repeater.
// Empty: enq passes straight through to deq. When the consumer holds
// do_repeat on an accepted beat, the beat is saved and replayed on deq until
// a deq handshake with do_repeat low releases it.
// `repeat` is a reserved word, so the consumer request is named do_repeat.
// Optional macro TL_A_REPEATER_ASSERT_EN compiles in simulation-only checks.
module tl_a_repeater #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 4,
  parameter int SRC_W  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             do_repeat,
  output logic             full,
  tl_a_repeater_if.slave   enq,
  tl_a_repeater_if.master  deq
);

  // One A-channel beat, packed so save/replay/compare act on a single value.
  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [SIZE_W-1:0]   size;
    logic [SRC_W-1:0]    source;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } beat_t;

  logic  full_q, full_d;
  beat_t saved_q, saved_d;
  beat_t enq_beat;
  beat_t deq_beat;
  logic  enq_ready_w;
  logic  deq_valid_w;
  logic  enq_fire;
  logic  deq_fire;

  assign enq_beat = {enq.opcode, enq.param, enq.size, enq.source,
                     enq.address, enq.mask, enq.data, enq.corrupt};

  // Output muxing: pass-through when empty, saved beat when full.
  assign deq_valid_w = full_q ? 1'b1 : enq.valid;
  assign enq_ready_w = full_q ? 1'b0 : deq.ready;
  assign deq_beat    = full_q ? saved_q : enq_beat;
  assign enq_fire    = enq.valid & enq_ready_w;
  assign deq_fire    = deq_valid_w & deq.ready;

  assign full        = full_q;
  assign enq.ready   = enq_ready_w;
  assign deq.valid   = deq_valid_w;
  assign deq.opcode  = deq_beat.opcode;
  assign deq.param   = deq_beat.param;
  assign deq.size    = deq_beat.size;
  assign deq.source  = deq_beat.source;
  assign deq.address = deq_beat.address;
  assign deq.mask    = deq_beat.mask;
  assign deq.data    = deq_beat.data;
  assign deq.corrupt = deq_beat.corrupt;

  // Next-state: capture on an accepted beat with do_repeat while empty,
  // release on a deq handshake without do_repeat while full.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    full_d  = full_q;
    saved_d = saved_q;
    if (!full_q && enq_fire && do_repeat) begin
      full_d  = 1'b1;
      saved_d = enq_beat;
    end else if (full_q && deq_fire && !do_repeat) begin
      full_d  = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      full_q  <= 1'b0;
      // NOTE: the single saved entry is a plain register, cheap to reset, so
      // it is cleared to give a defined value after reset.
      saved_q <= '0;
    end else begin
      full_q  <= full_d;
      saved_q <= saved_d;
    end
  end

`ifdef TL_A_REPEATER_ASSERT_EN
  // A stalled deq beat must stay valid and unchanged in the next cycle.
  a_deq_stable: assert property (@(posedge clock) disable iff (reset)
    (deq_valid_w && !deq.ready) |=> (deq_valid_w && $stable(deq_beat)))
    else $error("tl_a_repeater: deq beat changed or dropped while stalled");

  // Upstream is never accepted while a saved beat is replayed.
  a_no_ready_full: assert property (@(posedge clock) disable iff (reset)
    !(full_q && enq_ready_w))
    else $error("tl_a_repeater: enq_ready high while full");

  // full only rises after an accepted beat carrying do_repeat.
  a_full_rise: assert property (@(posedge clock) disable iff (reset)
    $rose(full_q) |-> $past(enq_fire && do_repeat))
    else $error("tl_a_repeater: full rose without a capture");
`else
  // Assertion checks not compiled in.
`endif

endmodule

// File: tb/tb_tl_a_repeater.sv
// Self-checking bench for tl_a_repeater: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_tl_a_repeater;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 4;
  localparam int SRC_W  = 2;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [SIZE_W-1:0]   size;
    logic [SRC_W-1:0]    source;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  logic do_repeat;
  logic full;

  tl_a_repeater_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .SRC_W(SRC_W)) enq_if ();
  tl_a_repeater_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .SRC_W(SRC_W)) deq_if ();

  tl_a_repeater #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .SRC_W(SRC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .do_repeat (do_repeat),
    .full      (full),
    .enq       (enq_if),
    .deq       (deq_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the beat held for replay; empty queue means pass-through.
  beat_t held[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic beat_t deq_beat();
    return {deq_if.opcode, deq_if.param, deq_if.size, deq_if.source,
            deq_if.address, deq_if.mask, deq_if.data, deq_if.corrupt};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.opcode  = 3'($urandom);
    b.param   = 3'($urandom);
    b.size    = SIZE_W'($urandom);
    b.source  = SRC_W'($urandom);
    b.address = ADDR_W'($urandom);
    b.mask    = (DATA_W/8)'($urandom);
    b.data    = DATA_W'($urandom);
    b.corrupt = 1'($urandom);
    return b;
  endfunction

  function automatic beat_t mk_beat(input logic [2:0] op, input logic [3:0] sz,
                                    input logic [1:0] src, input logic [31:0] addr,
                                    input logic [31:0] dat);
    beat_t b;
    b = '0;
    b.opcode  = op;
    b.size    = sz;
    b.source  = src;
    b.address = addr;
    b.mask    = '1;
    b.data    = dat;
    return b;
  endfunction

  // One cycle: drive at negedge, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic step(input logic v, input logic r, input logic rp, input logic rs,
                      input beat_t b, input string tag);
    logic  exp_full, exp_dv, exp_er;
    beat_t exp_b;
    @(negedge clock);
    reset          = rs;
    do_repeat      = rp;
    enq_if.valid   = v;
    deq_if.ready   = r;
    {enq_if.opcode, enq_if.param, enq_if.size, enq_if.source,
     enq_if.address, enq_if.mask, enq_if.data, enq_if.corrupt} = b;
    #1;
    exp_full = (held.size() != 0);
    exp_dv   = exp_full ? 1'b1 : v;
    exp_er   = exp_full ? 1'b0 : r;
    exp_b    = exp_full ? held[0] : b;
    check({tag, ".full"},      128'(full),         128'(exp_full));
    check({tag, ".deq_valid"}, 128'(deq_if.valid), 128'(exp_dv));
    check({tag, ".enq_ready"}, 128'(enq_if.ready), 128'(exp_er));
    check({tag, ".deq_beat"},  128'(deq_beat()),   128'(exp_b));
    // do_repeat must not reach any output combinationally.
    do_repeat = ~rp;
    #1;
    check({tag, ".rpt_path"}, 128'({deq_if.valid, enq_if.ready, full, deq_beat()}),
          128'({exp_dv, exp_er, exp_full, exp_b}));
    do_repeat = rp;
    @(posedge clock);
    if (rs) held.delete();
    else if (!exp_full) begin
      if (v && r && rp) held.push_back(b);
    end else if (r && !rp) held.delete();
  endtask

  beat_t get_b, put_b, nxt_b;

  initial begin
    reset = 1'b1;
    do_repeat = 1'b0;
    enq_if.valid = 1'b0;
    deq_if.ready = 1'b0;
    {enq_if.opcode, enq_if.param, enq_if.size, enq_if.source,
     enq_if.address, enq_if.mask, enq_if.data, enq_if.corrupt} = '0;
    repeat (2) @(posedge clock);

    // Reset state: pass-through, and a capture attempt under reset is ignored.
    step(1'b1, 1'b1, 1'b1, 1'b1, rand_beat(), "rst_capture");
    step(1'b1, 1'b0, 1'b0, 1'b0, rand_beat(), "post_rst");

    // Pass-through Get.
    get_b = mk_beat(3'd4, 4'd2, 2'd1, 32'h1000_0040, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, get_b, "pass_get");

    // Capture and triple replay of a PutFull.
    put_b = mk_beat(3'd0, 4'd2, 2'd2, 32'h8000_0000, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b1, 1'b0, put_b, "trip_cap");
    step(1'b1, 1'b1, 1'b1, 1'b0, rand_beat(), "trip_rep1");
    step(1'b1, 1'b1, 1'b0, 1'b0, rand_beat(), "trip_rep2");
    @(negedge clock);
    #1;
    check("trip_full_fall", 128'(full), 128'(1'b0));

    // Stall while full: deq_ready low, do_repeat toggling, enq changing.
    step(1'b1, 1'b1, 1'b1, 1'b0, rand_beat(), "stall_cap");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'(i % 2), 1'b0, rand_beat(), "stall");
    step(1'b1, 1'b1, 1'b0, 1'b0, rand_beat(), "stall_rel");

    // Back-to-back: release then a new beat passes with no bubble.
    step(1'b1, 1'b1, 1'b1, 1'b0, rand_beat(), "b2b_cap");
    step(1'b1, 1'b1, 1'b0, 1'b0, rand_beat(), "b2b_rel");
    nxt_b = mk_beat(3'd4, 4'd2, 2'd0, 32'h2000_0000, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, nxt_b, "b2b_next");

    // Reset mid-replay.
    step(1'b1, 1'b1, 1'b1, 1'b0, rand_beat(), "mid_cap");
    step(1'b1, 1'b1, 1'b1, 1'b1, rand_beat(), "mid_rst");
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_beat(), "mid_after");

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0),
           rand_beat(), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
